ex_operand_stage: RTL
=====================

# ex_operand_stage

Execute-stage front end of the 16-bit myMIPS pipeline, directly upstream of the `alu`. It holds the ID/EX pipeline register and resolves operands by forwarding from the MEM and WB stages. It detects load-use hazards and inserts bubbles, then drives `OP1`/`OP2`/`cmd` of the combinational `alu`. It also passes the destination-register control to the EX/MEM register.

## Interface
- `DATA_W`, 16, datapath width (matches `alu`).
- `REG_AW`, 3, register address width; r0 is hardwired zero.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `id_valid` in 1 — decode presents an instruction.
- `id_ready` out 1 — stage accepts the instruction this cycle.
- `id_rs`, `id_rt` in REG_AW — source register addresses.
- `id_rs_val`, `id_rt_val` in DATA_W — register-file read data.
- `id_imm` in DATA_W — sign-extended immediate.
- `id_use_imm` in 1 — OP2 takes the immediate; rt is not a source.
- `id_cmd` in 3 — ALU command (add 000, sub 001, sll 010, gt 011, srl 100, and 101, or 110, eq 111).
- `id_rd` in REG_AW — destination register.
- `id_wr_en` in 1 — instruction writes rd.
- `id_is_load` in 1 — instruction is a load.
- `mem_fwd_en` in 1 — MEM stage holds a forwardable ALU result for `mem_rd`.
- `mem_rd` in REG_AW — MEM-stage destination register.
- `mem_res` in DATA_W — MEM-stage ALU result.
- `wb_wr_en` in 1 — WB stage writes `wb_rd`.
- `wb_rd` in REG_AW — WB-stage destination register.
- `wb_data` in DATA_W — WB-stage write data.
- `ex_hold` in 1 — downstream stall; freeze this stage.
- `flush` in 1 — kill the instruction held in EX.
- `alu_op1`, `alu_op2` out DATA_W — to `alu` OP1/OP2.
- `alu_cmd` out 3 — to `alu` cmd.
- `ex_valid` out 1 — EX holds a real instruction.
- `ex_rd` out REG_AW — destination register passed to EX/MEM.
- `ex_wr_en` out 1 — write enable passed to EX/MEM.
- `ex_is_load` out 1 — load flag passed to EX/MEM.
- `hazard_cnt` out 16 — count of load-use bubble cycles, saturating.

## Operation
- ID/EX register fields: valid, rs, rt, rs_val, rt_val, imm, use_imm, cmd, rd, wr_en, is_load.
- Forward function `fwd(r, v)`:
  - if r==0 → 0;
  - else if `mem_fwd_en` && `mem_rd`==r → `mem_res`;
  - else if `wb_wr_en` && `wb_rd`==r → `wb_data`;
  - else v.
  - MEM has priority over WB.
- Operand selection:
  - `alu_op1` = fwd(rs, rs_val).
  - `alu_op2` = use_imm ? imm : fwd(rt, rt_val).
  - `alu_cmd` = cmd.
  - These outputs are combinational from the register and the forward inputs.
- Hazard condition, registered against the EX contents: ex_valid && is_load && wr_en && rd≠0 && id_valid && (id_rs==rd || (!id_use_imm && id_rt==rd)).
- `id_ready` = !hazard && !ex_hold.
- Per-cycle register update, in priority order:
  1. flush → valid←0; other fields unchanged.
  2. ex_hold → fields held; rs_val/rt_val ← fwd values, refreshed so a WB write during the hold is not lost.
  3. hazard → bubble: valid←0, wr_en←0, is_load←0.
  4. id_valid && id_ready → load all fields from ID.
  5. otherwise → valid←0, wr_en←0.
- Invalid entries never assert `ex_wr_en` or `ex_is_load`; the outputs are gated with valid.
- `hazard_cnt` increments on each cycle rule 3 fires and saturates at 0xFFFF.

## Timing
- Reset values:
  - All register fields are 0, so `ex_valid`=0, `ex_wr_en`=0, `ex_is_load`=0, `ex_rd`=0.
  - `alu_cmd`=000, `alu_op1`=`alu_op2`=0, `hazard_cnt`=0.
  - `id_ready`=1.
- Latency: an instruction accepted at edge N appears on the ALU inputs after edge N and on EX outputs for cycle N+1.
- Load-use: exactly one bubble cycle. The dependent instruction enters on the following edge, and its operand is forwarded from WB.
- `flush` and `ex_hold` asserted together: flush wins.
- `flush` and an accepted `id` together: flush wins; ID is not consumed because `id_ready` follows hold/hazard only, so decode must also drop the instruction on flush.
- Reset mid-hold or mid-bubble: all state clears immediately and asynchronously.

## Structure
- Package `mymips_pkg` holds:
  - `DATA_W` and `REG_AW` defaults;
  - `alu_cmd_t` enum (ADD, SUB, SLL, GT, SRL, AND, OR, EQ with the encodings above);
  - `id_ex_t` packed struct for the register fields.
- Sub-module `fwd_mux`: combinational forward function, instantiated twice (rs and rt).

## Test plan
- Reset, then accept add r1+r2 with rs_val=5, rt_val=7 → next cycle: alu_op1=5, alu_op2=7, alu_cmd=000, ex_valid=1.
- rs=3, rs_val=1, mem_fwd_en=1 mem_rd=3 mem_res=0x1234, wb_wr_en=1 wb_rd=3 wb_data=0x5555 → alu_op1=0x1234; drop mem_fwd_en → 0x5555; set rs=0 → alu_op1=0.
- Load to r4 in EX, then ID `sub` with rs=4 → id_ready=0 for one cycle, ex_valid=0 next, hazard_cnt=1; same with id_use_imm=1 and rt=4 → no stall.
- ex_hold for 3 cycles while a WB write to rt=2 of 0x00AA occurs → after release, alu_op2=0x00AA; fields unchanged; id_ready=0 throughout.
- flush with ex_hold=1 → ex_valid=0, ex_wr_en=0 next cycle.
- Force 65536 hazards → hazard_cnt stays 0xFFFF; rst_n low mid-sequence → all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/mymips_pkg.sv
// Shared types for the myMIPS 16-bit pipeline:
// widths, ALU command encoding and the ID/EX bundle.
package mymips_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int HCNT_W = 16;

  typedef enum logic [2:0] {
    CMD_ADD = 3'b000,
    CMD_SUB = 3'b001,
    CMD_SLL = 3'b010,
    CMD_GT  = 3'b011,
    CMD_SRL = 3'b100,
    CMD_AND = 3'b101,
    CMD_OR  = 3'b110,
    CMD_EQ  = 3'b111
  } alu_cmd_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    alu_cmd_t          cmd;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic              is_load;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forward select: r0 reads zero,
// MEM result beats WB data, else register-file value.
module fwd_mux #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] r_i,
  input  logic [DATA_W-1:0] v_i,
  input  logic              mem_fwd_en_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [DATA_W-1:0] mem_res_i,
  input  logic              wb_wr_en_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] val_o
);

  logic is_zero;
  logic mem_hit;
  logic wb_hit;

  assign is_zero = (r_i == '0);
  assign mem_hit = mem_fwd_en_i && (mem_rd_i == r_i);
  assign wb_hit  = wb_wr_en_i && (wb_rd_i == r_i);

  always_comb begin
    val_o = v_i;
    if (is_zero)      val_o = '0;
    else if (mem_hit) val_o = mem_res_i;
    else if (wb_hit)  val_o = wb_data_i;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// EX front end: ID/EX register, MEM/WB operand
// forwarding, load-use bubbles and ALU input drive.
module ex_operand_stage #(
  parameter int DATA_W = mymips_pkg::DATA_W,
  parameter int REG_AW = mymips_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [2:0]        id_cmd,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              mem_fwd_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_res,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_hold,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [2:0]        alu_cmd,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_wr_en,
  output logic              ex_is_load,
  output logic [15:0]       hazard_cnt
);
  import mymips_pkg::*;

  id_ex_t q, d;

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic              rs_dep;
  logic              rt_dep;
  logic              hazard;
  logic              bubble;
  logic [15:0]       hcnt_q;
  logic [15:0]       hcnt_d;

  fwd_mux #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rs (
    .r_i         (q.rs),
    .v_i         (q.rs_val),
    .mem_fwd_en_i(mem_fwd_en),
    .mem_rd_i    (mem_rd),
    .mem_res_i   (mem_res),
    .wb_wr_en_i  (wb_wr_en),
    .wb_rd_i     (wb_rd),
    .wb_data_i   (wb_data),
    .val_o       (rs_fwd)
  );

  fwd_mux #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rt (
    .r_i         (q.rt),
    .v_i         (q.rt_val),
    .mem_fwd_en_i(mem_fwd_en),
    .mem_rd_i    (mem_rd),
    .mem_res_i   (mem_res),
    .wb_wr_en_i  (wb_wr_en),
    .wb_rd_i     (wb_rd),
    .wb_data_i   (wb_data),
    .val_o       (rt_fwd)
  );

  assign rs_dep = (id_rs == q.rd);
  assign rt_dep = !id_use_imm && (id_rt == q.rd);

  assign hazard = q.valid && q.is_load && q.wr_en
               && (q.rd != '0) && id_valid
               && (rs_dep || rt_dep);

  assign id_ready = !hazard && !ex_hold;
  assign bubble   = !flush && !ex_hold && hazard;

  always_comb begin
    d = q;
    if (flush) begin
      d.valid = 1'b0;
    end else if (ex_hold) begin
      // refresh so a WB write landing during the stall survives
      d.rs_val = rs_fwd;
      d.rt_val = rt_fwd;
    end else if (hazard) begin
      d.valid   = 1'b0;
      d.wr_en   = 1'b0;
      d.is_load = 1'b0;
    end else if (id_valid && id_ready) begin
      d.valid   = 1'b1;
      d.rs      = id_rs;
      d.rt      = id_rt;
      d.rs_val  = id_rs_val;
      d.rt_val  = id_rt_val;
      d.imm     = id_imm;
      d.use_imm = id_use_imm;
      d.cmd     = alu_cmd_t'(id_cmd);
      d.rd      = id_rd;
      d.wr_en   = id_wr_en;
      d.is_load = id_is_load;
    end else begin
      d.valid = 1'b0;
      d.wr_en = 1'b0;
    end
  end

  always_comb begin
    hcnt_d = hcnt_q;
    if (bubble && (hcnt_q != 16'hFFFF)) begin
      hcnt_d = hcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      hcnt_q <= '0;
    end else begin
      q      <= d;
      hcnt_q <= hcnt_d;
    end
  end

  assign alu_op1    = rs_fwd;
  assign alu_op2    = q.use_imm ? q.imm : rt_fwd;
  assign alu_cmd    = q.cmd;
  assign ex_valid   = q.valid;
  assign ex_rd      = q.rd;
  assign ex_wr_en   = q.valid && q.wr_en;
  assign ex_is_load = q.valid && q.is_load;
  assign hazard_cnt = hcnt_q;

endmodule
